// File: rtl/max7219_pkg.sv
// Shared types and constants for the MAX7219 column-scroll engine.
// Data word layout is {pad, digit, column}.
package max7219_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_RAM,
    ST_WAIT_RAM,
    ST_SEND,
    ST_WAIT_DONE,
    ST_TEMPO,
    ST_UPDATE
  } state_t;

  localparam int PAD_W   = 4;
  localparam int DIGIT_W = 4;
  localparam int COL_W   = 8;
  localparam int WORD_W  = PAD_W + DIGIT_W + COL_W;

  localparam logic [DIGIT_W-1:0] DIGIT_FIRST = 4'd1;
  localparam logic [DIGIT_W-1:0] DIGIT_LAST  = 4'd8;

endpackage

// File: rtl/max7219_scroll_ram.sv
// Column RAM: host read/write port plus engine read-only port.
// Both ports have one cycle of read latency; only the read registers are reset.
module max7219_scroll_ram #(
  parameter int G_ADDR_W = 8,
  parameter int G_DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_me,
  input  logic                i_we,
  input  logic [G_ADDR_W-1:0] i_addr,
  input  logic [G_DATA_W-1:0] i_wdata,
  output logic [G_DATA_W-1:0] o_rdata,
  input  logic                i_eng_en,
  input  logic [G_ADDR_W-1:0] i_eng_addr,
  output logic [G_DATA_W-1:0] o_eng_rdata
);

  logic [G_DATA_W-1:0] r_mem [0:(2**G_ADDR_W)-1];
  logic [G_DATA_W-1:0] r_rdata;
  logic [G_DATA_W-1:0] r_eng_rdata;

  always_ff @(posedge clk) begin
    if (i_me && i_we) r_mem[i_addr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rdata     <= '0;
      r_eng_rdata <= '0;
    end else begin
      if (i_me && !i_we) r_rdata <= r_mem[i_addr];
      if (i_eng_en)      r_eng_rdata <= r_mem[i_eng_addr];
    end
  end

  assign o_rdata     = r_rdata;
  assign o_eng_rdata = r_eng_rdata;

endmodule

// File: rtl/max7219_scroll_engine.sv
// Scrolls a circular column message across a chain of MAX7219 8x8 matrices,
// one frame of 8*G_MATRIX_NB words per tempo tick.
module max7219_scroll_engine
  import max7219_pkg::*;
#(
  parameter int G_MATRIX_NB      = 8,
  parameter int G_RAM_ADDR_WIDTH = 8,
  parameter int G_RAM_DATA_WIDTH = 8,
  parameter int G_TEMPO_WIDTH    = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_me,
  input  logic                        i_we,
  input  logic [G_RAM_ADDR_WIDTH-1:0] i_addr,
  input  logic [G_RAM_DATA_WIDTH-1:0] i_wdata,
  output logic [G_RAM_DATA_WIDTH-1:0] o_rdata,
  input  logic [G_RAM_ADDR_WIDTH-1:0] i_ram_start_ptr,
  input  logic [G_RAM_ADDR_WIDTH-1:0] i_msg_length,
  input  logic [G_TEMPO_WIDTH-1:0]    i_max_tempo_cnt,
  input  logic                        i_start_scroll,
  input  logic                        i_stop_scroll,
  input  logic                        i_dir,
  input  logic                        i_loop,
  input  logic                        i_max7219_if_done,
  output logic                        o_max7219_if_start,
  output logic                        o_max7219_if_en_load,
  output logic [WORD_W-1:0]           o_max7219_if_data,
  output logic                        o_busy,
  output logic                        o_scroll_done
);

  localparam int AW = G_RAM_ADDR_WIDTH;
  localparam int TW = G_TEMPO_WIDTH;
  localparam int MW = (G_MATRIX_NB > 1) ? $clog2(G_MATRIX_NB) : 1;
  localparam int PW = AW + 8;
  localparam logic [MW-1:0] MAT_LAST = MW'(G_MATRIX_NB - 1);

  state_t r_state, w_state_nxt;

  logic [AW-1:0]       r_start_ptr, r_len, r_offset;
  logic [TW-1:0]       r_tempo, r_tempo_cnt;
  logic                r_dir, r_loop, r_stop;
  logic [DIGIT_W-1:0]  r_digit;
  logic [MW-1:0]       r_mat;
  logic [WORD_W-1:0]   r_data;
  logic                r_en_load;
  logic                r_done;

  logic [PW-1:0]               w_pos;
  logic [AW-1:0]               w_idx, w_eng_addr, w_offset_nxt;
  logic [G_RAM_DATA_WIDTH-1:0] w_eng_rdata;
  logic                        w_last_word, w_done_set, w_start_ok;

  max7219_scroll_ram #(
    .G_ADDR_W (AW),
    .G_DATA_W (G_RAM_DATA_WIDTH)
  ) u_ram (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_me        (i_me),
    .i_we        (i_we),
    .i_addr      (i_addr),
    .i_wdata     (i_wdata),
    .o_rdata     (o_rdata),
    .i_eng_en    (r_state == ST_RD_RAM),
    .i_eng_addr  (w_eng_addr),
    .o_eng_rdata (w_eng_rdata)
  );

  // Message index wraps on length first, RAM address wraps on the address width.
  assign w_pos       = PW'(r_offset) + PW'({r_mat, 3'b000}) + PW'(r_digit - DIGIT_FIRST);
  assign w_idx       = AW'(w_pos % PW'(r_len));
  assign w_eng_addr  = r_start_ptr + w_idx;
  assign w_last_word = (r_digit == DIGIT_LAST) && (r_mat == '0);
  assign w_start_ok  = i_start_scroll && (i_msg_length != '0);

  always_comb begin
    w_offset_nxt = r_offset;
    if (!r_dir) w_offset_nxt = (r_offset == r_len - AW'(1)) ? '0 : r_offset + AW'(1);
    else        w_offset_nxt = (r_offset == '0) ? r_len - AW'(1) : r_offset - AW'(1);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done_set  = 1'b0;
    case (r_state)
      ST_IDLE:      if (w_start_ok) w_state_nxt = ST_RD_RAM;
      ST_RD_RAM:    w_state_nxt = ST_WAIT_RAM;
      ST_WAIT_RAM:  w_state_nxt = ST_SEND;
      ST_SEND:      w_state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (i_max7219_if_done) begin
          if (!w_last_word) begin
            w_state_nxt = ST_RD_RAM;
          end else if (r_stop) begin
            w_state_nxt = ST_IDLE;
            w_done_set  = 1'b1;
          end else begin
            w_state_nxt = ST_TEMPO;
          end
        end
      end
      ST_TEMPO: begin
        // A stop that lands after the last word still ends before the next frame.
        if (r_stop) begin
          w_state_nxt = ST_IDLE;
          w_done_set  = 1'b1;
        end else if (r_tempo_cnt == r_tempo) begin
          w_state_nxt = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        if (r_stop || ((w_offset_nxt == '0) && !r_loop)) begin
          w_state_nxt = ST_IDLE;
          w_done_set  = 1'b1;
        end else begin
          w_state_nxt = ST_RD_RAM;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_start_ptr <= '0;
      r_len       <= '0;
      r_offset    <= '0;
      r_tempo     <= '0;
      r_tempo_cnt <= '0;
      r_dir       <= 1'b0;
      r_loop      <= 1'b0;
      r_stop      <= 1'b0;
      r_digit     <= DIGIT_FIRST;
      r_mat       <= MAT_LAST;
      r_data      <= '0;
      r_en_load   <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_set;
      case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            r_start_ptr <= i_ram_start_ptr;
            r_len       <= i_msg_length;
            r_tempo     <= i_max_tempo_cnt;
            r_dir       <= i_dir;
            r_loop      <= i_loop;
            r_offset    <= '0;
            r_tempo_cnt <= '0;
            r_stop      <= 1'b0;
            r_digit     <= DIGIT_FIRST;
            r_mat       <= MAT_LAST;
          end
        end
        ST_WAIT_RAM: begin
          r_data    <= {{PAD_W{1'b0}}, r_digit, w_eng_rdata};
          r_en_load <= (r_mat == '0);
        end
        ST_WAIT_DONE: begin
          if (i_max7219_if_done && !w_last_word) begin
            if (r_mat == '0) begin
              r_digit <= r_digit + DIGIT_W'(1);
              r_mat   <= MAT_LAST;
            end else begin
              r_mat <= r_mat - MW'(1);
            end
          end
        end
        ST_TEMPO: r_tempo_cnt <= r_tempo_cnt + TW'(1);
        ST_UPDATE: begin
          r_offset    <= w_offset_nxt;
          r_tempo_cnt <= '0;
          r_digit     <= DIGIT_FIRST;
          r_mat       <= MAT_LAST;
        end
        default: ;
      endcase
      if ((r_state != ST_IDLE) && i_stop_scroll) r_stop <= 1'b1;
    end
  end

  assign o_max7219_if_start   = (r_state == ST_SEND);
  assign o_max7219_if_en_load = r_en_load;
  assign o_max7219_if_data    = r_data;
  assign o_busy               = (r_state != ST_IDLE);
  assign o_scroll_done        = r_done;

endmodule

// File: tb/tb_max7219_scroll_engine.sv
// Directed + randomized bench for the scroll engine (4 matrices) against a
// frame/word reference model built from the display arithmetic.
`timescale 1ns/1ps
module tb_max7219_scroll_engine;

  localparam int NB = 4;
  localparam int WPF = 8 * NB;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_me, i_we;
  logic [7:0]  i_addr, i_wdata, o_rdata;
  logic [7:0]  i_ram_start_ptr, i_msg_length;
  logic [31:0] i_max_tempo_cnt;
  logic        i_start_scroll, i_stop_scroll, i_dir, i_loop;
  logic        i_max7219_if_done = 1'b0;
  logic        o_start, o_en_load, o_busy, o_scroll_done;
  logic [15:0] o_data;

  int n_cmp = 0;
  int n_bad = 0;
  int n_unstable = 0;
  bit hold_done = 1'b0;
  logic [7:0]  ram_m [256];
  logic [16:0] q [$];

  max7219_scroll_engine #(
    .G_MATRIX_NB(NB), .G_RAM_ADDR_WIDTH(8), .G_RAM_DATA_WIDTH(8), .G_TEMPO_WIDTH(32)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_me(i_me), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata), .o_rdata(o_rdata),
    .i_ram_start_ptr(i_ram_start_ptr), .i_msg_length(i_msg_length),
    .i_max_tempo_cnt(i_max_tempo_cnt), .i_start_scroll(i_start_scroll),
    .i_stop_scroll(i_stop_scroll), .i_dir(i_dir), .i_loop(i_loop),
    .i_max7219_if_done(i_max7219_if_done), .o_max7219_if_start(o_start),
    .o_max7219_if_en_load(o_en_load), .o_max7219_if_data(o_data),
    .o_busy(o_busy), .o_scroll_done(o_scroll_done)
  );

  always #5 clk = ~clk;

  // Serializer stand-in: logs each word, acks after 1..3 cycles, checks word stability.
  always begin
    logic [16:0] w;
    int k;
    @(negedge clk);
    if (rst_n && o_start) begin
      w = {o_en_load, o_data};
      q.push_back(w);
      k = $urandom_range(1, 3);
      for (int i = 0; i < k; i++) begin
        @(negedge clk);
        if (i == 0 && o_start) n_unstable++;
        if (o_busy && ({o_en_load, o_data} !== w)) n_unstable++;
      end
      while (hold_done) @(negedge clk);
      i_max7219_if_done = 1'b1;
      @(negedge clk);
      i_max7219_if_done = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Word n of a frame: digit-major, highest matrix first.
  function automatic logic [16:0] exp_word(int sp, int len, int off, int n);
    int d = n / NB + 1;
    int m = NB - 1 - (n % NB);
    int a = (sp + (off + 8 * m + d - 1) % len) % 256;
    logic [3:0] dg = 4'(d);
    logic ld = (m == 0);
    return {ld, 4'h0, dg, ram_m[a]};
  endfunction

  function automatic int frame_off(int len, bit dir, int f);
    return dir ? (len - (f % len)) % len : f % len;
  endfunction

  task automatic host_wr(input int a, input logic [7:0] d);
    @(negedge clk); i_me = 1; i_we = 1; i_addr = 8'(a); i_wdata = d;
    @(negedge clk); i_me = 0; i_we = 0;
    ram_m[a] = d;
  endtask

  task automatic wait_sdone(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (o_scroll_done) begin ok = 1; break; end
    end
  endtask

  task automatic cmp_frames(input string tag, input int sp, input int len, input bit dir, input int nfr);
    chk({tag, "_nwords"}, q.size(), nfr * WPF);
    for (int f = 0; f < nfr; f++)
      for (int n = 0; n < WPF; n++)
        if (f * WPF + n < q.size())
          chk($sformatf("%s_f%0d_w%0d", tag, f, n), q[f * WPF + n], exp_word(sp, len, frame_off(len, dir, f), n));
  endtask

  task automatic run_scroll(input string tag, input int sp, input int len, input int tempo,
                            input bit dir, input bit with_stop);
    bit ok;
    q.delete();
    @(negedge clk);
    i_ram_start_ptr = 8'(sp); i_msg_length = 8'(len); i_max_tempo_cnt = tempo;
    i_dir = dir; i_loop = 0; i_start_scroll = 1; i_stop_scroll = with_stop;
    @(negedge clk);
    i_start_scroll = 0; i_stop_scroll = 0;
    chk({tag, "_busy_up"}, o_busy, 1);
    repeat (50) @(negedge clk);
    i_msg_length = 8'd3; i_start_scroll = 1;
    @(negedge clk);
    i_start_scroll = 0;
    wait_sdone(len * (WPF * 8 + tempo + 8) + 200, ok);
    chk({tag, "_done_seen"}, ok, 1);
    chk({tag, "_busy_low"}, o_busy, 0);
    @(negedge clk);
    chk({tag, "_done_1cyc"}, o_scroll_done, 0);
    cmp_frames(tag, sp, len, dir, len);
  endtask

  initial begin
    bit ok;
    int sp, len;
    rst_n = 0; i_me = 0; i_we = 0; i_addr = 0; i_wdata = 0;
    i_ram_start_ptr = 0; i_msg_length = 0; i_max_tempo_cnt = 0;
    i_start_scroll = 0; i_stop_scroll = 0; i_dir = 0; i_loop = 0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {o_busy, o_scroll_done, o_start, o_en_load, o_data, o_rdata}, 0);
    rst_n = 1;

    for (int i = 0; i < 256; i++) host_wr(i, (i < 32) ? 8'(i) : 8'($urandom));

    // host read: one-cycle latency, then hold
    @(negedge clk); i_me = 1; i_we = 0; i_addr = 8'd7;
    @(negedge clk); i_me = 0;
    chk("host_rd_7", o_rdata, ram_m[7]);
    @(negedge clk);
    chk("host_rd_hold", o_rdata, ram_m[7]);

    // zero length start is ignored
    @(negedge clk); i_msg_length = 0; i_start_scroll = 1;
    @(negedge clk); i_start_scroll = 0;
    @(negedge clk);
    chk("len0_busy", o_busy, 0);

    run_scroll("left32", 0, 32, 10, 0, 0);
    chk("left32_first", q.size() > 0 ? q[0] : 17'h1ffff, 17'h00118);
    chk("left32_fourth", q.size() > 3 ? q[3] : 17'h1ffff, 17'h10100);

    run_scroll("right32", 0, 32, 10, 1, 0);
    chk("right32_f1w0", q.size() > WPF ? 32'(q[WPF][7:0]) : 32'hff, 23);

    run_scroll("wrap5", 250, 5, 2, 0, 0);
    run_scroll("start_stop", 3, 2, 0, 1, 1);
    for (int r = 0; r < 2; r++) begin
      sp = $urandom_range(0, 255);
      len = $urandom_range(1, 20);
      run_scroll($sformatf("rnd%0d", r), sp, len, $urandom_range(0, 4), 1'($urandom_range(0, 1)), 0);
    end

    // loop mode with a stop request mid third frame
    q.delete();
    @(negedge clk);
    i_ram_start_ptr = 0; i_msg_length = 32; i_max_tempo_cnt = 3; i_dir = 0; i_loop = 1;
    i_start_scroll = 1;
    @(negedge clk); i_start_scroll = 0;
    host_wr(200, 8'hA5);
    ok = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (q.size() >= 2 * WPF + 10) begin ok = 1; break; end
    end
    chk("stop_reach_f2", ok, 1);
    i_stop_scroll = 1;
    @(negedge clk); i_stop_scroll = 0;
    wait_sdone(3000, ok);
    chk("stop_done_seen", ok, 1);
    chk("stop_busy_low", o_busy, 0);
    @(negedge clk);
    chk("stop_done_1cyc", o_scroll_done, 0);
    cmp_frames("stop", 0, 32, 0, 3);
    begin
      int nl = 0;
      for (int i = 2 * WPF; i < q.size(); i++) nl += q[i][16];
      chk("stop_last_loads", nl, 8);
    end
    @(negedge clk); i_me = 1; i_we = 0; i_addr = 8'd200;
    @(negedge clk); i_me = 0;
    chk("wr_while_busy", o_rdata, 8'hA5);

    // reset while waiting for the serializer ack
    hold_done = 1;
    @(negedge clk);
    i_ram_start_ptr = 0; i_msg_length = 32; i_max_tempo_cnt = 1; i_dir = 0; i_loop = 0;
    i_start_scroll = 1;
    @(negedge clk); i_start_scroll = 0;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (o_start) begin ok = 1; break; end
      @(negedge clk);
    end
    chk("rst_saw_start", ok, 1);
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    chk("rst_mid_outputs", {o_busy, o_scroll_done, o_start, o_en_load, o_data, o_rdata}, 0);
    rst_n = 1;
    ok = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (o_start) ok = 1;
    end
    chk("rst_no_restart", ok, 0);
    hold_done = 0;
    repeat (6) @(negedge clk);
    run_scroll("replay", 0, 4, 1, 0, 0);

    chk("word_stability", n_unstable, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/max7219_scroll_engine.md
MAX7219_SCROLL_ENGINE -- requirements
Module: max7219_scroll_engine

Interface
REQ-001 The block SHALL have parameter G_MATRIX_NB, default 8, giving the number of daisy-chained 8x8 matrices (1..16).
REQ-002 The block SHALL have parameter G_RAM_ADDR_WIDTH, default 8, giving the column RAM address width.
REQ-003 The block SHALL have parameter G_RAM_DATA_WIDTH, default 8, giving the column RAM data width; it is fixed at 8 (one column per byte).
REQ-004 The block SHALL have parameter G_TEMPO_WIDTH, default 32, giving the tempo counter width.
REQ-005 The block SHALL have these ports:
- clk  in  1  clock, single clock domain.
- rst_n  in  1  reset; synchronous, active-low.
REQ-006 The block SHALL have these host RAM ports:
- i_me  in  1  memory enable.
- i_we  in  1  write enable.
- i_addr  in  G_RAM_ADDR_WIDTH  address.
- i_wdata  in  8  write data.
- o_rdata  out  8  read data.
REQ-007 The block SHALL have these control ports:
- i_ram_start_ptr  in  G_RAM_ADDR_WIDTH  first message column.
- i_msg_length  in  G_RAM_ADDR_WIDTH  message length in columns.
- i_max_tempo_cnt  in  G_TEMPO_WIDTH  frame interval.
- i_start_scroll  in  1  start pulse.
- i_stop_scroll  in  1  stop request pulse.
- i_dir  in  1  direction: 0 left, 1 right.
- i_loop  in  1  repeat mode.
REQ-008 The block SHALL have these MAX7219 interface ports:
- i_max7219_if_done  in  1  word sent.
- o_max7219_if_start  out  1  word start pulse.
- o_max7219_if_en_load  out  1  LOAD after this word.
- o_max7219_if_data  out  16  {4'h0, digit[3:0], column[7:0]}.
REQ-009 The block SHALL have these status ports:
- o_busy  out  1  scroll active.
- o_scroll_done  out  1  one-cycle pulse at end of scroll.

Function
REQ-010 A host write (i_me=1, i_we=1) SHALL update RAM[i_addr] at any time, including while busy.
REQ-011 A host read (i_me=1, i_we=0) SHALL present RAM[i_addr] on o_rdata one cycle later; o_rdata SHALL hold its value otherwise.
REQ-012 On i_start_scroll in IDLE with i_msg_length != 0, the block SHALL latch start_ptr, length, tempo, dir and loop, clear offset to 0, and raise o_busy on the next cycle.
REQ-013 i_start_scroll SHALL be ignored while busy, and SHALL be ignored when i_msg_length == 0.
REQ-014 The FSM SHALL have states IDLE, RD_RAM, WAIT_RAM, SEND, WAIT_DONE, TEMPO and UPDATE.
REQ-015 A frame SHALL send, for digits d=1..8 (outer loop) and matrices m=G_MATRIX_NB-1..0 (inner loop), the column RAM[(start_ptr + (offset + 8m + d-1) mod length) mod 2^G_RAM_ADDR_WIDTH].
REQ-016 Each frame word SHALL be RD_RAM -> WAIT_RAM (1-cycle RAM latency) -> SEND, with o_max7219_if_start high for exactly one cycle and data/en_load stable from SEND until i_max7219_if_done.
REQ-017 o_max7219_if_en_load SHALL be 1 only on the m=0 word of each digit.
REQ-018 After the 8*G_MATRIX_NB-th done, the FSM SHALL enter TEMPO and count i_max_tempo_cnt+1 cycles before UPDATE.
REQ-019 In UPDATE, offset SHALL become (offset+1) mod length for dir=0 and (offset-1+length) mod length for dir=1.
REQ-020 When offset returns to 0 and loop=0, the block SHALL go to IDLE, drop o_busy and pulse o_scroll_done; when loop=1 it SHALL continue.
REQ-021 i_stop_scroll while busy SHALL be registered; the current frame SHALL complete, then the block SHALL go to IDLE with an o_scroll_done pulse and skip TEMPO.
REQ-022 i_start_scroll and i_stop_scroll in the same cycle in IDLE SHALL be treated as start only.
REQ-023 A length shorter than the display (length < 8*G_MATRIX_NB) SHALL wrap the message repeatedly across the display.

Reset
REQ-024 While rst_n=0 at a clk edge, the FSM SHALL enter IDLE and all outputs SHALL be 0.
REQ-025 While rst_n=0 at a clk edge, offset, the tempo counter and the stop flag SHALL be cleared; RAM contents are not reset.
REQ-026 A reset mid-frame SHALL abort the frame without issuing a further start.

Structure
REQ-027 Package max7219_pkg SHALL hold the FSM state enum, the digit range constants (1..8) and the data-word field widths.
REQ-028 The RAM SHALL be one sub-module, max7219_scroll_ram: a dual-port RAM with a host read/write port and an engine read-only port, both with 1-cycle read latency.

Verification
REQ-029 G_MATRIX_NB=4, RAM[0..31]=0..31, start_ptr=0, length=32, tempo=10, loop=0 -> 32 words per frame; the first word is {digit 1, col 24} with en_load=0; the 4th word is {digit 1, col 0} with en_load=1; 32 frames are sent, then o_scroll_done.
REQ-030 Same setup, dir=1 -> the second frame's first word is column (31+24) mod 32 = 23.
REQ-031 length=5, start_ptr=250, G_MATRIX_NB=1 -> digit d shows RAM[(250+d-1 mod 5) mod 256]; no address beyond 254 is read.
REQ-032 loop=1, i_stop_scroll asserted mid-frame -> the frame completes (all 8 LOAD pulses), then o_busy=0 and a one-cycle o_scroll_done.
REQ-033 With i_msg_length=0, i_start_scroll -> o_busy remains 0; a start while busy -> no change in word sequence.
REQ-034 rst_n=0 asserted during WAIT_DONE -> all outputs are 0 next cycle; a fresh start replays from offset 0.
